rect_intp_bilinear: RTL and testbench

- Downstream consumer of rect_intp_fifo in the rectification datapath.
- The upstream coordinate stage pushes one fractional-weight word per output pixel into the FIFO. In parallel, the line-buffer fetch delivers the matching 2x2 pixel quad.
- This block pops the weight word in lock-step with each quad, computes a rounded bilinear interpolation and emits rectified pixels with line/frame framing flags.

---
 rtl/rect_pkg.sv | 16 +
 rtl/rect_lerp.sv | 35 +++
 rtl/rect_intp_bilinear.sv | 205 ++++++++++++++++++++
 tb/tb_rect_intp_bilinear.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rect_pkg.sv
// Shared constants for the rectification interpolation slice.
// Holds the default pixel/fraction widths, the weight-word layout, and the
// default frame geometry used by rect_intp_bilinear.
package rect_pkg;

   localparam int FB_DEF     = 4;
   localparam int PW_DEF     = 8;

   localparam int FRAC_X_LSB = 0;
   localparam int FRAC_Y_LSB = FRAC_X_LSB + FB_DEF;
   localparam int OOB_BIT    = FRAC_Y_LSB + FB_DEF;

   localparam int H_SIZE_DEF = 640;
   localparam int V_SIZE_DEF = 480;

endpackage

// File: rtl/rect_lerp.sv
// Single weighted 2-tap blend: y = a*(2^FB - f) + b*f.
// The result keeps FB extra bits so that no precision is lost before the
// final rounding stage downstream.
module rect_lerp #(
   parameter int AW = 8,
   parameter int FB = 4
) (
   input  logic [AW-1:0]    a,
   input  logic [AW-1:0]    b,
   input  logic [FB-1:0]    f,
   output logic [AW+FB-1:0] y
);

   localparam int YW = AW + FB;

   logic [FB:0]   wa;
   logic [YW-1:0] a_ext;
   logic [YW-1:0] b_ext;
   logic [YW-1:0] wa_ext;
   logic [YW-1:0] f_ext;

   // Weight of the 'a' tap is the complement of f against 2^FB, which needs
   // one more bit than f itself (f = 0 gives the full weight 2^FB).
   assign wa     = {1'b1, {FB{1'b0}}} - {1'b0, f};

   // Everything is widened to the result width first; the sum of both
   // products never exceeds max(a,b) * 2^FB, so it always fits in YW bits.
   assign a_ext  = {{FB{1'b0}}, a};
   assign b_ext  = {{FB{1'b0}}, b};
   assign wa_ext = {{(AW-1){1'b0}}, wa};
   assign f_ext  = {{AW{1'b0}}, f};

   assign y      = a_ext * wa_ext + b_ext * f_ext;

endmodule

// File: rtl/rect_intp_bilinear.sv
// Bilinear interpolation stage of the rectification datapath.
// Pops one weight word per incoming pixel quad, blends the quad horizontally
// then vertically with round-half-up, and emits rectified pixels together
// with start-of-frame / end-of-line / end-of-frame framing flags.
module rect_intp_bilinear
   import rect_pkg::*;
#(
   parameter int W      = 28,
   parameter int FB     = FB_DEF,
   parameter int PW     = PW_DEF,
   parameter int H_SIZE = H_SIZE_DEF,
   parameter int V_SIZE = V_SIZE_DEF,
   parameter int FILL   = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_start,
   input  logic          pix_vld,
   input  logic [PW-1:0] pix_p00,
   input  logic [PW-1:0] pix_p01,
   input  logic [PW-1:0] pix_p10,
   input  logic [PW-1:0] pix_p11,
   output logic          fifo_rd,
   input  logic [W-1:0]  fifo_dout,
   output logic          out_vld,
   output logic [PW-1:0] out_pix,
   output logic          out_sof,
   output logic          out_eol,
   output logic          out_eof,
   output logic          err_ovf
);

   // Field positions follow the package layout but are derived from this
   // instance's FB so that a narrower or wider fraction still lines up.
   localparam int FX_LSB  = FRAC_X_LSB;
   localparam int FY_LSB  = FX_LSB + FB;
   localparam int OOB_POS = FY_LSB + FB;

   localparam int AW1 = PW + FB;
   localparam int AW2 = PW + 2 * FB;
   localparam int CW  = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
   localparam int RW  = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;

   localparam logic [AW2:0]    RND      = (AW2 + 1)'(2 ** (2 * FB - 1));
   localparam logic [CW-1:0]   COL_LAST = CW'(H_SIZE - 1);
   localparam logic [RW-1:0]   ROW_LAST = RW'(V_SIZE - 1);
   localparam logic [PW-1:0]   FILL_PIX = PW'(FILL);

   logic          s0_vld;
   logic [PW-1:0] s0_p00;
   logic [PW-1:0] s0_p01;
   logic [PW-1:0] s0_p10;
   logic [PW-1:0] s0_p11;

   logic [FB-1:0]  fx;
   logic [FB-1:0]  fy;
   logic           oob;
   logic [AW1-1:0] top_c;
   logic [AW1-1:0] bot_c;

   logic           s1_vld;
   logic [AW1-1:0] s1_top;
   logic [AW1-1:0] s1_bot;
   logic [FB-1:0]  s1_fy;
   logic           s1_oob;

   logic [AW2-1:0] acc;
   logic [AW2:0]   acc_r;
   logic [AW2:0]   shifted;
   logic [PW-1:0]  pix_c;

   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic           done;
   logic           sof_c;
   logic           eol_c;
   logic           eof_c;

   // The FIFO pops in the same cycle the quad arrives; its head word then
   // shows up one cycle later, exactly when the quad sits in S0.
   assign fifo_rd = pix_vld;

   assign fx  = fifo_dout[FX_LSB +: FB];
   assign fy  = fifo_dout[FY_LSB +: FB];
   assign oob = fifo_dout[OOB_POS];

   // Horizontal blends of the top and bottom rows share the same x weight.
   rect_lerp #(.AW(PW), .FB(FB)) u_top (
      .a (s0_p00),
      .b (s0_p01),
      .f (fx),
      .y (top_c)
   );

   rect_lerp #(.AW(PW), .FB(FB)) u_bot (
      .a (s0_p10),
      .b (s0_p11),
      .f (fx),
      .y (bot_c)
   );

   // Vertical blend of the two registered row results.
   rect_lerp #(.AW(AW1), .FB(FB)) u_vert (
      .a (s1_top),
      .b (s1_bot),
      .f (s1_fy),
      .y (acc)
   );

   // Round half up, drop the 2*FB fraction bits, clamp, and substitute FILL
   // for coordinates that fell outside the source image.
   always_comb begin
      acc_r   = {1'b0, acc} + RND;
      shifted = acc_r >> (2 * FB);
      pix_c   = shifted[PW-1:0];
      if (s1_oob) begin
         pix_c = FILL_PIX;
      end else if (|shifted[AW2:PW]) begin
         pix_c = '1;
      end
   end

   // Framing flags describe the pixel currently in S2; once the frame is
   // done every further pixel goes out unflagged.
   always_comb begin
      sof_c = !done && (col == '0) && (row == '0);
      eol_c = !done && (col == COL_LAST);
      eof_c = eol_c && (row == ROW_LAST);
   end

   // S0 captures the quad; S1 captures the row blends and the y weight.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_vld <= 1'b0;
         s0_p00 <= '0;
         s0_p01 <= '0;
         s0_p10 <= '0;
         s0_p11 <= '0;
         s1_vld <= 1'b0;
         s1_top <= '0;
         s1_bot <= '0;
         s1_fy  <= '0;
         s1_oob <= 1'b0;
      end else begin
         s0_vld <= pix_vld;
         s0_p00 <= pix_p00;
         s0_p01 <= pix_p01;
         s0_p10 <= pix_p10;
         s0_p11 <= pix_p11;
         s1_vld <= s0_vld;
         s1_top <= top_c;
         s1_bot <= bot_c;
         s1_fy  <= fy;
         s1_oob <= oob;
      end
   end

   // Output register; data and flags are forced low between valid pixels.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld <= 1'b0;
         out_pix <= '0;
         out_sof <= 1'b0;
         out_eol <= 1'b0;
         out_eof <= 1'b0;
         err_ovf <= 1'b0;
      end else begin
         out_vld <= s1_vld;
         out_pix <= s1_vld ? pix_c : '0;
         out_sof <= s1_vld & sof_c;
         out_eol <= s1_vld & eol_c;
         out_eof <= s1_vld & eof_c;
         if (s1_vld && done) begin
            err_ovf <= 1'b1;
         end
      end
   end

   // Column/row position of the pixel in S2; frame_start takes priority so
   // that the very next pixel is treated as the first of a new frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         col  <= '0;
         row  <= '0;
         done <= 1'b0;
      end else if (frame_start) begin
         col  <= '0;
         row  <= '0;
         done <= 1'b0;
      end else if (s1_vld && !done) begin
         if (eol_c) begin
            col <= '0;
            if (eof_c) begin
               row  <= '0;
               done <= 1'b1;
            end else begin
               row <= row + RW'(1);
            end
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_rect_intp_bilinear.sv
// Directed testbench for rect_intp_bilinear with a small 4x2 frame and a
// behavioural weight FIFO that presents the popped word one cycle later.
module tb_rect_intp_bilinear;

   localparam int W  = 28;
   localparam int FB = 4;
   localparam int PW = 8;
   localparam int HS = 4;
   localparam int VS = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_start;
   logic          pix_vld;
   logic [PW-1:0] pix_p00;
   logic [PW-1:0] pix_p01;
   logic [PW-1:0] pix_p10;
   logic [PW-1:0] pix_p11;
   logic          fifo_rd;
   logic [W-1:0]  fifo_dout;
   logic          out_vld;
   logic [PW-1:0] out_pix;
   logic          out_sof;
   logic          out_eol;
   logic          out_eof;
   logic          err_ovf;

   logic [W-1:0]  fifo_mem [0:15];
   logic [3:0]    rd_ptr;
   logic [3:0]    wr_ptr;

   int checks = 0;
   int errors = 0;

   rect_intp_bilinear #(
      .W      (W),
      .FB     (FB),
      .PW     (PW),
      .H_SIZE (HS),
      .V_SIZE (VS),
      .FILL   (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .pix_vld     (pix_vld),
      .pix_p00     (pix_p00),
      .pix_p01     (pix_p01),
      .pix_p10     (pix_p10),
      .pix_p11     (pix_p11),
      .fifo_rd     (fifo_rd),
      .fifo_dout   (fifo_dout),
      .out_vld     (out_vld),
      .out_pix     (out_pix),
      .out_sof     (out_sof),
      .out_eol     (out_eol),
      .out_eof     (out_eof),
      .err_ovf     (err_ovf)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Pre-increment FIFO model: the head word is the entry after the last pop.
   assign fifo_dout = fifo_mem[rd_ptr];

   // Advance the model's read pointer on each pop.
   always @(posedge clk) begin
      if (rst) rd_ptr <= 4'd0;
      else if (fifo_rd) rd_ptr <= rd_ptr + 4'd1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Push a weight word (junk in the ignored upper bits) and present a quad.
   task automatic drive_pixel(input int p00, input int p01, input int p10,
                              input int p11, input int fx, input int fy,
                              input bit oob);
      fifo_mem[wr_ptr] = {19'h55555, oob, 4'(fy), 4'(fx)};
      wr_ptr  = wr_ptr + 4'd1;
      pix_vld = 1'b1;
      pix_p00 = PW'(p00);
      pix_p01 = PW'(p01);
      pix_p10 = PW'(p10);
      pix_p11 = PW'(p11);
   endtask

   task automatic idle();
      pix_vld = 1'b0;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      frame_start = 1'b0;
      pix_vld     = 1'b0;
      pix_p00     = '0;
      pix_p01     = '0;
      pix_p10     = '0;
      pix_p11     = '0;
      wr_ptr      = 4'd1;
      for (int i = 0; i < 16; i++) fifo_mem[i] = '0;
      step();
      step();
      checks++;
      if ({out_vld, out_sof, out_eol, out_eof, err_ovf, fifo_rd} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 000000",
                  {out_vld, out_sof, out_eol, out_eof, err_ovf, fifo_rd});
      end
      checks++;
      if (out_pix !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_pix: got %0d expected 0", out_pix);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_interp();
      int q   [4][4] = '{'{10, 20, 30, 40}, '{10, 20, 30, 40},
                         '{0, 1, 0, 1}, '{255, 255, 255, 255}};
      int fxs [4]    = '{0, 8, 8, 15};
      int fys [4]    = '{0, 8, 0, 15};
      int exp_pix [4] = '{10, 25, 1, 255};
      for (int i = 0; i < 4; i++) begin
         drive_pixel(q[i][0], q[i][1], q[i][2], q[i][3], fxs[i], fys[i], 1'b0);
         #1;
         checks++;
         if (fifo_rd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL interp_fifo_rd[%0d]: got %b expected 1", i, fifo_rd);
         end
         step();
         idle();
         for (int c = 1; c <= 3; c++) begin
            checks++;
            if (out_vld !== (c == 3)) begin
               errors++;
               $display("[TB] FAIL interp_latency[%0d] cycle %0d: out_vld %b expected %b",
                        i, c, out_vld, (c == 3));
            end
            if (c < 3) step();
         end
         checks++;
         if (out_pix !== PW'(exp_pix[i])) begin
            errors++;
            $display("[TB] FAIL interp_pix[%0d]: got %0d expected %0d", i, out_pix, exp_pix[i]);
         end
         checks++;
         if ({out_sof, out_eol, out_eof} !== {(i == 0), (i == 3), 1'b0}) begin
            errors++;
            $display("[TB] FAIL interp_flags[%0d]: got %b expected %b", i,
                     {out_sof, out_eol, out_eof}, {(i == 0), (i == 3), 1'b0});
         end
         step();
      end
   endtask

   task automatic test_oob();
      drive_pixel(50, 60, 70, 80, 5, 9, 1'b1);
      step();
      drive_pixel(0, 16, 32, 48, 4, 12, 1'b0);
      step();
      idle();
      step();
      checks++;
      if ({out_vld, out_pix} !== {1'b1, 8'd0}) begin
         errors++;
         $display("[TB] FAIL oob_fill: vld %b pix %0d expected vld 1 pix 0", out_vld, out_pix);
      end
      step();
      checks++;
      if ({out_vld, out_pix} !== {1'b1, 8'd28}) begin
         errors++;
         $display("[TB] FAIL oob_next_aligned: vld %b pix %0d expected vld 1 pix 28",
                  out_vld, out_pix);
      end
      checks++;
      if ({out_sof, out_eol, out_eof} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL oob_flags: got %b expected 000", {out_sof, out_eol, out_eof});
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_f;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i < 9) drive_pixel(10 + i, 10 + i, 10 + i, 10 + i, 0, 0, 1'b0);
         else idle();
         if (i >= 3) begin
            int j;
            j = i - 3;
            exp_f = {1'b1, (j == 0), (j == 3 || j == 7), (j == 7), (j >= 8)};
            checks++;
            if ({out_vld, out_sof, out_eol, out_eof, err_ovf} !== exp_f) begin
               errors++;
               $display("[TB] FAIL b2b_flags[%0d]: vld/sof/eol/eof/ovf got %b expected %b",
                        j, {out_vld, out_sof, out_eol, out_eof, err_ovf}, exp_f);
            end
            checks++;
            if (out_pix !== PW'(10 + j)) begin
               errors++;
               $display("[TB] FAIL b2b_pix[%0d]: got %0d expected %0d", j, out_pix, 10 + j);
            end
         end
         step();
      end
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      drive_pixel(77, 77, 77, 77, 0, 0, 1'b0);
      step();
      idle();
      step();
      step();
      checks++;
      if ({out_vld, out_sof, err_ovf} !== 3'b111 || out_pix !== 8'd77) begin
         errors++;
         $display("[TB] FAIL restart_sof_ovf: vld/sof/ovf %b pix %0d expected 111 pix 77",
                  {out_vld, out_sof, err_ovf}, out_pix);
      end
      step();
   endtask

   task automatic test_reset_flush();
      rst    = 1'b1;
      wr_ptr = 4'd1;
      step();
      rst = 1'b0;
      checks++;
      if (err_ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_clears_ovf: got %b expected 0", err_ovf);
      end
      drive_pixel(90, 90, 90, 90, 0, 0, 1'b0);
      step();
      drive_pixel(91, 91, 91, 91, 0, 0, 1'b0);
      step();
      idle();
      rst    = 1'b1;
      wr_ptr = 4'd1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({out_vld, out_sof, out_eol, out_eof, err_ovf} !== 5'b0 || out_pix !== 8'd0) begin
            errors++;
            $display("[TB] FAIL flush[%0d]: vld/sof/eol/eof/ovf %b pix %0d expected 00000 pix 0",
                     c, {out_vld, out_sof, out_eol, out_eof, err_ovf}, out_pix);
         end
         step();
      end
      drive_pixel(0, 16, 32, 48, 4, 12, 1'b0);
      step();
      idle();
      step();
      step();
      checks++;
      if ({out_vld, out_sof} !== 2'b11 || out_pix !== 8'd28) begin
         errors++;
         $display("[TB] FAIL post_flush: vld/sof %b pix %0d expected 11 pix 28",
                  {out_vld, out_sof}, out_pix);
      end
      step();
   endtask

   initial begin
      $display("[TB] rect_intp_bilinear directed test start");
      test_reset();
      test_interp();
      test_oob();
      test_back_to_back();
      test_reset_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
